mem_read_arbiter: RTL and testbench

//  Shares the single memory AXI read channel (AR + R) between I-cache (requester 0) and D-cache (requester 1).

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_rr_pick.sv | 27 ++
 rtl/mem_read_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_read_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory read arbiter
//
// Contents:
//   arb_state_t  IDLE -> REQ -> DATA -> IDLE burst state
//   NUM_REQ      number of requesters sharing the read channel
//   REQ_ICACHE   requester index of the I-cache refill FSM
//   REQ_DCACHE   requester index of the D-cache refill FSM
package mem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// rtl/mem_arb_rr_pick.sv - combinational two-way round-robin winner select
//
// Ports:
//   eligible  in   NUM_REQ  requesters allowed to win this cycle
//   prio      in   1        requester favoured when both are eligible
//   winner    out  1        index of the winning requester
//   any       out  1        at least one requester is eligible
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible,
    input  logic               prio,
    output logic               winner,
    output logic               any
);

    always_comb begin
        any = |eligible;
        // With a single contender the priority pointer is irrelevant.
        if (&eligible) begin
            winner = prio;
        end else begin
            winner = eligible[REQ_DCACHE];
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - shares one AXI read channel between I-cache and D-cache
//
// Build option: MEM_ARB_RAW_FENCE_EN blocks D-cache grants while wr_pending is high.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_arvalid/s_arready           per-requester request, one-cycle accept pulse
//   s_araddr/s_arlen              packed request address and beat count (req0 in low bits)
//   s_rvalid/s_rdata              per-requester beat valid, broadcast data
//   m_arvalid/m_arready           memory read-address handshake
//   m_araddr/m_arlen/m_arid       latched request fields, id = {3'b0, owner}
//   m_rvalid/m_rready/m_rdata     memory read data (always ready)
//   wr_pending                    D-cache has an unacknowledged write in flight
//   err_stray                     sticky flag for a beat received outside DATA
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 26,
    parameter int DW = 32,
    parameter int LW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    s_arvalid,
    output logic [NUM_REQ-1:0]    s_arready,
    input  logic [NUM_REQ*AW-1:0] s_araddr,
    input  logic [NUM_REQ*LW-1:0] s_arlen,
    output logic [NUM_REQ-1:0]    s_rvalid,
    output logic [DW-1:0]         s_rdata,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [AW-1:0]         m_araddr,
    output logic [LW-1:0]         m_arlen,
    output logic [3:0]            m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [DW-1:0]         m_rdata,
    input  logic                  wr_pending,
    output logic                  err_stray
);

    arb_state_t         state;
    logic               prio;
    logic               owner;
    logic [LW-1:0]      beat_cnt;
    logic [AW-1:0]      addr_q;
    logic [LW-1:0]      len_q;

    logic [NUM_REQ-1:0] eligible;
    logic               winner;
    logic               any;
    logic               grant;
    logic               last_beat;

    always_comb begin
        eligible = s_arvalid;
`ifdef MEM_ARB_RAW_FENCE_EN
        // Keep D-cache refills behind its own outstanding write; I-cache is never fenced.
        if (wr_pending) begin
            eligible[REQ_DCACHE] = 1'b0;
        end
`else
        // wr_pending has no effect without the fence.
        eligible[REQ_DCACHE] = s_arvalid[REQ_DCACHE] | (wr_pending & 1'b0);
`endif
        eligible[REQ_ICACHE] = s_arvalid[REQ_ICACHE];
    end

    mem_arb_rr_pick u_pick (
        .eligible (eligible),
        .prio     (prio),
        .winner   (winner),
        .any      (any)
    );

    // A grant made during reset would never be latched, so suppress the accept pulse.
    assign grant = (state == IDLE) && any && !rst;

    // len_q - 1 wraps, so len 0 finishes at beat_cnt 15 (a full 2^LW burst).
    assign last_beat = (state == DATA) && m_rvalid && (beat_cnt == len_q - LW'(1));

    always_comb begin
        s_arready = '0;
        if (grant) begin
            s_arready[winner] = 1'b1;
        end
        s_rvalid = '0;
        if ((state == DATA) && !rst) begin
            s_rvalid[owner] = m_rvalid;
        end
    end

    assign s_rdata   = m_rdata;
    assign m_rready  = 1'b1;
    assign m_arvalid = (state == REQ);
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arid    = {3'b000, owner};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            beat_cnt  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            err_stray <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_rvalid) begin
                        err_stray <= 1'b1;
                    end
                    if (any) begin
                        owner  <= winner;
                        addr_q <= winner ? s_araddr[2*AW-1:AW] : s_araddr[AW-1:0];
                        len_q  <= winner ? s_arlen[2*LW-1:LW]  : s_arlen[LW-1:0];
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (m_rvalid) begin
                        err_stray <= 1'b1;
                    end
                    if (m_arready) begin
                        state    <= DATA;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (m_rvalid) begin
                        beat_cnt <= beat_cnt + LW'(1);
                    end
                    if (last_beat) begin
                        state <= IDLE;
                        prio  <= ~owner;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb/tb_mem_read_arbiter.sv - scoreboard testbench for mem_read_arbiter
module tb_mem_read_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk;
    logic            rst;
    logic [1:0]      s_arvalid;
    logic [1:0]      s_arready;
    logic [2*AW-1:0] s_araddr;
    logic [2*LW-1:0] s_arlen;
    logic [1:0]      s_rvalid;
    logic [DW-1:0]   s_rdata;
    logic            m_arvalid;
    logic            m_arready;
    logic [AW-1:0]   m_araddr;
    logic [LW-1:0]   m_arlen;
    logic [3:0]      m_arid;
    logic            m_rvalid;
    logic            m_rready;
    logic [DW-1:0]   m_rdata;
    logic            wr_pending;
    logic            err_stray;

    int tests;
    int fails;

    // Expected AR: {id, addr, len}; expected beat: {id, data}.
    logic [AW+LW:0] ar_q[$];
    logic [DW:0]    beat_q[$];

    mem_read_arbiter #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_araddr   (s_araddr),
        .s_arlen    (s_arlen),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_araddr   (m_araddr),
        .m_arlen    (m_arlen),
        .m_arid     (m_arid),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .m_rdata    (m_rdata),
        .wr_pending (wr_pending),
        .err_stray  (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of request inputs at the falling edge; outputs are sampled 1ns later.
    task automatic request(input logic [1:0] v, input logic [AW-1:0] a0, input logic [LW-1:0] l0,
                           input logic [AW-1:0] a1, input logic [LW-1:0] l1);
        @(negedge clk);
        s_arvalid = v;
        s_araddr  = {a1, a0};
        s_arlen   = {l1, l0};
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        #1;
    endtask

    // Memory side of one burst: AR wait states, accept, then beats from the scoreboard.
    task automatic drive_burst(input logic [1:0] hold_valid, input int ar_wait);
        logic [AW+LW:0] ar_exp;
        logic [DW:0]    b_exp;
        int             nbeats;
        if (ar_q.size() == 0) begin
            fails++;
            tests++;
            $display("FAIL ar_queue: actual empty, required an expected request");
            return;
        end
        ar_exp = ar_q.pop_front();
        nbeats = (ar_exp[LW-1:0] == '0) ? 16 : int'(ar_exp[LW-1:0]);
        for (int i = 0; i <= ar_wait; i++) begin
            @(negedge clk);
            s_arvalid = hold_valid;
            m_arready = (i == ar_wait);
            m_rvalid  = 1'b0;
            #1;
            tests++;
            if ({m_arvalid, m_arid, m_araddr, m_arlen} !==
                {1'b1, 3'b000, ar_exp[AW+LW], ar_exp[AW+LW-1:0]}) begin
                fails++;
                $display("FAIL ar_fields: actual v=%0b id=%0d addr=%h len=%0d, required v=1 id=%0d addr=%h len=%0d",
                         m_arvalid, m_arid, m_araddr, m_arlen, ar_exp[AW+LW], ar_exp[AW+LW-1:LW], ar_exp[LW-1:0]);
            end
            tests++;
            if (s_arready !== 2'b00) begin
                fails++;
                $display("FAIL arready_busy: actual %b, required 00", s_arready);
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rdata   = $urandom;
            beat_q.push_back({ar_exp[AW+LW], m_rdata});
            #1;
            b_exp = beat_q.pop_front();
            tests++;
            if (s_rvalid !== (b_exp[DW] ? 2'b10 : 2'b01) || s_rdata !== b_exp[DW-1:0]) begin
                fails++;
                $display("FAIL beat%0d: actual rvalid=%b data=%h, required rvalid=%b data=%h",
                         b, s_rvalid, s_rdata, (b_exp[DW] ? 2'b10 : 2'b01), b_exp[DW-1:0]);
            end
        end
    endtask

    task automatic test_reset();
        s_arvalid = '0; s_araddr = '0; s_arlen = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; wr_pending = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({m_arvalid, s_arready, s_rvalid, m_araddr, m_arlen, m_arid, err_stray} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: actual arv=%b ardy=%b rv=%b addr=%h len=%h id=%h err=%b, required all 0",
                     m_arvalid, s_arready, s_rvalid, m_araddr, m_arlen, m_arid, err_stray);
        end
    endtask

    task automatic test_single();
        request(2'b01, 26'h0100, 4'd4, 26'h0, 4'd0);
        tests++;
        if (s_arready !== 2'b01 || m_arvalid !== 1'b0) begin
            fails++;
            $display("FAIL single_grant: actual ardy=%b arv=%b, required ardy=01 arv=0", s_arready, m_arvalid);
        end
        ar_q.push_back({1'b0, 26'h0100, 4'd4});
        drive_burst(2'b00, 2);
        request(2'b00, 26'h0, 4'd0, 26'h0, 4'd0);
        tests++;
        if (m_arvalid !== 1'b0 || s_rvalid !== 2'b00) begin
            fails++;
            $display("FAIL single_idle: actual arv=%b rv=%b, required arv=0 rv=00", m_arvalid, s_rvalid);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        request(2'b11, 26'h0200, 4'd2, 26'h0300, 4'd3);
        tests++;
        if (s_arready !== 2'b01) begin
            fails++;
            $display("FAIL sim_first: actual ardy=%b, required 01", s_arready);
        end
        ar_q.push_back({1'b0, 26'h0200, 4'd2});
        drive_burst(2'b10, 0);
        // The cycle after the last beat is the bubble in which req1 is granted.
        request(2'b10, 26'h0200, 4'd2, 26'h0300, 4'd3);
        tests++;
        if (s_arready !== 2'b10 || m_arvalid !== 1'b0) begin
            fails++;
            $display("FAIL sim_second: actual ardy=%b arv=%b, required ardy=10 arv=0", s_arready, m_arvalid);
        end
        ar_q.push_back({1'b1, 26'h0300, 4'd3});
        drive_burst(2'b00, 1);
        request(2'b11, 26'h0400, 4'd1, 26'h0500, 4'd1);
        tests++;
        if (s_arready !== 2'b01) begin
            fails++;
            $display("FAIL sim_third: actual ardy=%b, required 01", s_arready);
        end
        ar_q.push_back({1'b0, 26'h0400, 4'd1});
        drive_burst(2'b10, 0);
        // Leftover req1 now wins.
        request(2'b10, 26'h0400, 4'd1, 26'h0500, 4'd1);
        tests++;
        if (s_arready !== 2'b10) begin
            fails++;
            $display("FAIL sim_fourth: actual ardy=%b, required 10", s_arready);
        end
        ar_q.push_back({1'b1, 26'h0500, 4'd1});
        drive_burst(2'b00, 0);
    endtask

    task automatic test_sixteen_beats();
        request(2'b10, 26'h0, 4'd0, 26'h1000, 4'd0);
        tests++;
        if (s_arready !== 2'b10) begin
            fails++;
            $display("FAIL len0_grant: actual ardy=%b, required 10", s_arready);
        end
        ar_q.push_back({1'b1, 26'h1000, 4'd0});
        drive_burst(2'b00, 0);
        request(2'b00, 26'h0, 4'd0, 26'h0, 4'd0);
        tests++;
        if (m_arvalid !== 1'b0 || dut.state !== mem_arb_pkg::IDLE) begin
            fails++;
            $display("FAIL len0_idle: actual arv=%b state=%0d, required arv=0 state=0", m_arvalid, dut.state);
        end
    endtask

    task automatic test_stray();
        @(negedge clk);
        s_arvalid = 2'b00;
        m_rvalid  = 1'b1;
        m_rdata   = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (s_rvalid !== 2'b00 || err_stray !== 1'b0) begin
            fails++;
            $display("FAIL stray_drop: actual rv=%b err=%b, required rv=00 err=0", s_rvalid, err_stray);
        end
        request(2'b00, 26'h0, 4'd0, 26'h0, 4'd0);
        tests++;
        if (err_stray !== 1'b1) begin
            fails++;
            $display("FAIL stray_set: actual %b, required 1", err_stray);
        end
        request(2'b01, 26'h0040, 4'd1, 26'h0, 4'd0);
        ar_q.push_back({1'b0, 26'h0040, 4'd1});
        drive_burst(2'b00, 0);
        request(2'b00, 26'h0, 4'd0, 26'h0, 4'd0);
        tests++;
        if (err_stray !== 1'b1) begin
            fails++;
            $display("FAIL stray_sticky: actual %b, required 1", err_stray);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (err_stray !== 1'b0) begin
            fails++;
            $display("FAIL stray_clear: actual %b, required 0", err_stray);
        end
    endtask

    task automatic test_fence();
`ifdef MEM_ARB_RAW_FENCE_EN
        wr_pending = 1'b1;
        for (int i = 0; i < 3; i++) begin
            request(2'b10, 26'h0, 4'd0, 26'h0800, 4'd2);
            tests++;
            if (s_arready !== 2'b00) begin
                fails++;
                $display("FAIL fence_hold%0d: actual ardy=%b, required 00", i, s_arready);
            end
        end
        wr_pending = 1'b0;
        request(2'b10, 26'h0, 4'd0, 26'h0800, 4'd2);
        tests++;
        if (s_arready !== 2'b10) begin
            fails++;
            $display("FAIL fence_release: actual ardy=%b, required 10", s_arready);
        end
        ar_q.push_back({1'b1, 26'h0800, 4'd2});
        drive_burst(2'b00, 0);
        wr_pending = 1'b1;
        request(2'b01, 26'h0900, 4'd1, 26'h0, 4'd0);
        tests++;
        if (s_arready !== 2'b01) begin
            fails++;
            $display("FAIL fence_req0: actual ardy=%b, required 01", s_arready);
        end
        ar_q.push_back({1'b0, 26'h0900, 4'd1});
        drive_burst(2'b00, 0);
        wr_pending = 1'b0;
`else
        wr_pending = 1'b1;
        request(2'b10, 26'h0, 4'd0, 26'h0800, 4'd2);
        tests++;
        if (s_arready !== 2'b10) begin
            fails++;
            $display("FAIL nofence_grant: actual ardy=%b, required 10", s_arready);
        end
        ar_q.push_back({1'b1, 26'h0800, 4'd2});
        drive_burst(2'b00, 0);
        wr_pending = 1'b0;
`endif
    endtask

    task automatic test_mid_burst_reset();
        logic [DW:0] b_exp;
        request(2'b01, 26'h0A00, 4'd8, 26'h0, 4'd0);
        @(negedge clk);
        s_arvalid = 2'b00;
        m_arready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            m_arready = 1'b0;
            m_rvalid  = 1'b1;
            m_rdata   = $urandom;
            beat_q.push_back({1'b0, m_rdata});
            #1;
            b_exp = beat_q.pop_front();
            tests++;
            if (s_rvalid !== 2'b01 || s_rdata !== b_exp[DW-1:0]) begin
                fails++;
                $display("FAIL mid_beat%0d: actual rv=%b data=%h, required rv=01 data=%h",
                         b, s_rvalid, s_rdata, b_exp[DW-1:0]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        m_rdata = $urandom;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({m_arvalid, s_arready, s_rvalid, m_araddr, m_arlen, m_arid, err_stray} !== '0 ||
            dut.state !== mem_arb_pkg::IDLE) begin
            fails++;
            $display("FAIL mid_reset: actual state=%0d arv=%b ardy=%b rv=%b addr=%h len=%h id=%h err=%b, required IDLE and all 0",
                     dut.state, m_arvalid, s_arready, s_rvalid, m_araddr, m_arlen, m_arid, err_stray);
        end
        @(negedge clk);
        m_rvalid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_simultaneous();
        test_sixteen_beats();
        test_stray();
        test_fence();
        test_mid_burst_reset();
        tests++;
        if (ar_q.size() != 0 || beat_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: actual ar=%0d beats=%0d left, required 0", ar_q.size(), beat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
